// File: rtl/aes_ks_inv.sv
// Inverse AES key-schedule walker: steps backward from the last round key to K0,
// one key per accepted enable, for AES-128 and AES-256.
module aes_ks_inv (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [1:0]   size_i,
  input  logic [255:0] key_i,
  output logic [127:0] ks_o,
  output logic [3:0]   round_o,
  output logic         done_o,
  output logic         err_o
);

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned RND_W  = 4;

  localparam logic [1:0]       SIZE_128   = 2'd0;
  localparam logic [1:0]       SIZE_256   = 2'd2;
  localparam logic [7:0]       RCON_128   = 8'h36;
  localparam logic [7:0]       RCON_256   = 8'h40;
  localparam logic [RND_W-1:0] LAST_128   = RND_W'(10);
  localparam logic [RND_W-1:0] LAST_256   = RND_W'(14);

  logic [KEY_W-1:0] r_win_hi;
  logic [KEY_W-1:0] r_win_lo;
  logic [7:0]       r_rcon;
  logic             r_is256;
  logic             r_par;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse as a^254, then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [KEY_W-1:0]  w_cur;
  logic [WORD_W-1:0] w_p3, w_p2, w_p1;
  logic [WORD_W-1:0] w_src, w_sub_in, w_t;
  logic              w_use_rot;
  logic [KEY_W-1:0]  w_prev;
  logic              w_step;

  // AES-128 inverts the key in win_hi; AES-256 inverts win_lo using win_hi.w3 as helper
  assign w_cur     = r_is256 ? r_win_lo : r_win_hi;
  assign w_p3      = w_cur[31:0]  ^ w_cur[63:32];
  assign w_p2      = w_cur[63:32] ^ w_cur[95:64];
  assign w_p1      = w_cur[95:64] ^ w_cur[127:96];
  assign w_src     = r_is256 ? r_win_hi[31:0] : w_p3;
  assign w_use_rot = !r_is256 || r_par;
  assign w_sub_in  = w_use_rot ? {w_src[23:0], w_src[31:24]} : w_src;
  assign w_t       = sub_word(w_sub_in) ^ (w_use_rot ? {r_rcon, 24'h000000} : 32'h0);
  assign w_prev    = {w_cur[127:96] ^ w_t, w_p1, w_p2, w_p3};
  assign w_step    = en_i && (round_o != '0) && !err_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win_hi <= '0;
      r_win_lo <= '0;
      r_rcon   <= '0;
      r_is256  <= 1'b0;
      r_par    <= 1'b0;
      ks_o     <= '0;
      round_o  <= '0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else if (load_i) begin
      if (size_i == SIZE_128) begin
        r_win_hi <= key_i[255:128];
        r_win_lo <= '0;
        r_rcon   <= RCON_128;
        r_is256  <= 1'b0;
        r_par    <= 1'b0;
        ks_o     <= key_i[255:128];
        round_o  <= LAST_128;
        done_o   <= 1'b0;
        err_o    <= 1'b0;
      end else if (size_i == SIZE_256) begin
        r_win_hi <= key_i[255:128];
        r_win_lo <= key_i[127:0];
        r_rcon   <= RCON_256;
        r_is256  <= 1'b1;
        r_par    <= 1'b1;
        ks_o     <= key_i[127:0];
        round_o  <= LAST_256;
        done_o   <= 1'b0;
        err_o    <= 1'b0;
      end else begin
        r_win_hi <= '0;
        r_win_lo <= '0;
        r_rcon   <= '0;
        r_is256  <= 1'b0;
        r_par    <= 1'b0;
        ks_o     <= '0;
        round_o  <= '0;
        done_o   <= 1'b1;
        err_o    <= 1'b1;
      end
    end else if (w_step) begin
      round_o <= round_o - RND_W'(1);
      done_o  <= (round_o == RND_W'(1));
      if (r_is256 && (round_o == LAST_256)) begin
        // K13 is already held in the window, so the first step only exposes it
        ks_o <= r_win_hi;
      end else begin
        ks_o     <= w_prev;
        r_win_hi <= w_prev;
        if (r_is256) begin
          r_win_lo <= r_win_hi;
          r_par    <= ~r_par;
          if (r_par) r_rcon <= r_rcon >> 1;
        end else begin
          r_rcon <= (r_rcon == 8'h1b) ? 8'h80 : (r_rcon >> 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_ks_inv.sv
// Scoreboard bench for aes_ks_inv: expected keys come from an independent forward key expansion.
module tb_aes_ks_inv;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_i;
  logic         en_i;
  logic [1:0]   size_i;
  logic [255:0] key_i;
  logic [127:0] ks_o;
  logic [3:0]   round_o;
  logic         done_o;
  logic         err_o;

  typedef struct packed {
    logic [127:0] ks;
    logic [3:0]   rnd;
    logic         done;
    logic         err;
  } exp_t;

  exp_t         sb_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [7:0]   sb [256];
  logic [127:0] k128 [11];
  logic [127:0] k128a [11];
  logic [127:0] k256 [15];

  localparam logic [127:0] K10_A1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K9_A1  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K0_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K0_A3  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] K1_A3  = 128'h1f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes_ks_inv dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load_i),
    .en_i    (en_i),
    .size_i  (size_i),
    .key_i   (key_i),
    .ks_o    (ks_o),
    .round_o (round_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    logic [7:0] bb;
    r = 0; aa = a; bb = b;
    while (bb != 0) begin
      if (bb[0]) r ^= aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return r;
  endfunction

  // S-box table by brute-force inverse search and the bitwise affine formula
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[a] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [31:0] rotw(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  task automatic expand128(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subw(rotw(t)) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) k128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic expand256(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw(rotw(t)) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) k256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic exp_t mk(input logic [127:0] ks, input int rnd, input logic done,
                              input logic err);
    exp_t e;
    e.ks = ks; e.rnd = 4'(rnd); e.done = done; e.err = err;
    return e;
  endfunction

  // Drive one cycle on the falling edge, queue the expectation, compare after the rising edge
  task automatic step(input string tag, input logic r, input logic ld, input logic en,
                      input logic [1:0] sz, input logic [255:0] k, input exp_t e);
    exp_t x;
    @(negedge clk);
    rst_n = r; load_i = ld; en_i = en; size_i = sz; key_i = k;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check({tag, ".ks"},    ks_o,            x.ks);
    check({tag, ".round"}, 128'(round_o),   128'(x.rnd));
    check({tag, ".done"},  128'(done_o),    128'(x.done));
    check({tag, ".err"},   128'(err_o),     128'(x.err));
  endtask

  logic [255:0] rnd_key;
  logic [255:0] kin;

  initial begin
    rst_n = 1'b0; load_i = 1'b0; en_i = 1'b0; size_i = 2'd0; key_i = '0;
    build_sbox();
    rnd_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

    step("rst0", 1'b0, 1'b1, 1'b1, 2'd0, rnd_key, mk('0, 0, 0, 0));
    step("rst1", 1'b0, 1'b0, 1'b1, 2'd2, rnd_key, mk('0, 0, 0, 0));

    // AES-128 single step then full walk with en held
    expand128(K0_A1);
    k128a = k128;
    kin = {K10_A1, rnd_key[127:0]};
    step("a128_load", 1'b1, 1'b1, 1'b0, 2'd0, kin, mk(K10_A1, 10, 0, 0));
    step("a128_k9",   1'b1, 1'b0, 1'b1, 2'd0, kin, mk(K9_A1, 9, 0, 0));
    for (int r = 8; r >= 0; r--)
      step($sformatf("a128_k%0d", r), 1'b1, 1'b0, 1'b1, 2'd0, kin,
           mk(k128a[r], r, r == 0, 0));
    step("a128_hold0", 1'b1, 1'b0, 1'b1, 2'd0, kin, mk(K0_A1, 0, 1, 0));
    step("a128_hold1", 1'b1, 1'b0, 1'b1, 2'd0, kin, mk(K0_A1, 0, 1, 0));

    // AES-256 walk from K13/K14
    expand256({K0_A3, K1_A3});
    kin = {k256[13], k256[14]};
    step("a256_load", 1'b1, 1'b1, 1'b0, 2'd2, kin, mk(k256[14], 14, 0, 0));
    for (int r = 13; r >= 0; r--)
      step($sformatf("a256_k%0d", r), 1'b1, 1'b0, 1'b1, 2'd2, kin,
           mk(r == 1 ? K1_A3 : (r == 0 ? K0_A3 : k256[r]), r, r == 0, 0));
    step("a256_hold", 1'b1, 1'b0, 1'b1, 2'd2, kin, mk(K0_A3, 0, 1, 0));

    // Unsupported sizes, then recovery with a valid load
    step("err_s1",  1'b1, 1'b1, 1'b0, 2'd1, rnd_key, mk('0, 0, 1, 1));
    step("err_en",  1'b1, 1'b0, 1'b1, 2'd0, rnd_key, mk('0, 0, 1, 1));
    step("err_s3",  1'b1, 1'b1, 1'b1, 2'd3, rnd_key, mk('0, 0, 1, 1));
    kin = {K10_A1, 128'h0};
    step("err_clr", 1'b1, 1'b1, 1'b0, 2'd0, kin, mk(K10_A1, 10, 0, 0));

    // Stall with en toggling, then load+en together at round 5
    step("stall_en1",  1'b1, 1'b0, 1'b1, 2'd0, kin, mk(k128a[9], 9, 0, 0));
    step("stall_idle", 1'b1, 1'b0, 1'b0, 2'd0, kin, mk(k128a[9], 9, 0, 0));
    step("stall_en2",  1'b1, 1'b0, 1'b1, 2'd0, kin, mk(k128a[8], 8, 0, 0));
    for (int r = 7; r >= 5; r--)
      step($sformatf("stall_k%0d", r), 1'b1, 1'b0, 1'b1, 2'd0, kin, mk(k128a[r], r, 0, 0));
    expand128(128'h000102030405060708090a0b0c0d0e0f);
    kin = {k128[10], rnd_key[255:128]};
    step("restart_load", 1'b1, 1'b1, 1'b1, 2'd0, kin, mk(k128[10], 10, 0, 0));
    for (int r = 9; r >= 6; r--)
      step($sformatf("restart_k%0d", r), 1'b1, 1'b0, 1'b1, 2'd0, kin, mk(k128[r], r, 0, 0));

    // Reset mid-walk at round 6; en alone cannot restart
    step("mid_rst",  1'b0, 1'b0, 1'b1, 2'd0, kin, mk('0, 0, 0, 0));
    step("post_en0", 1'b1, 1'b0, 1'b1, 2'd0, kin, mk('0, 0, 0, 0));
    step("post_en1", 1'b1, 1'b0, 1'b1, 2'd0, kin, mk('0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
